// File: rtl/param_flag_sampler.sv
// rtl/param_flag_sampler.sv - fixed-latency word pipeline with per-word flag select, saturating flag counter and optional edge detect
// Edge detect is built only when PARAM_FLAG_SAMPLER_EDGE_DET_EN is defined; otherwise flag_rise/flag_fall tie to 0.
module param_flag_sampler #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8,
    localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] sel,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_flag,
    output logic [CNT_W-1:0] flag_cnt,
    output logic             flag_rise,
    output logic             flag_fall
);

    logic [DEPTH-1:0] stg_valid;
    logic [WIDTH-1:0] stg_data [DEPTH];
    logic [SEL_W-1:0] stg_sel  [DEPTH];

    // Stage payload only loads behind a valid upstream word, so the last
    // stage naturally holds the most recent valid word through bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stg_data[i] <= '0;
                stg_sel[i]  <= '0;
            end
        end else begin
            stg_valid[0] <= in_valid;
            if (in_valid) begin
                stg_data[0] <= in_data;
                stg_sel[0]  <= sel;
            end
            for (int i = 1; i < DEPTH; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                if (stg_valid[i-1]) begin
                    stg_data[i] <= stg_data[i-1];
                    stg_sel[i]  <= stg_sel[i-1];
                end
            end
        end
    end

    assign out_valid = stg_valid[DEPTH-1];
    assign out_data  = stg_data[DEPTH-1];

    // Explicit compare per bit keeps out-of-range selects at 0 without an
    // out-of-bounds index.
    always_comb begin
        out_flag = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (stg_sel[DEPTH-1] == SEL_W'(i)) begin
                out_flag = stg_data[DEPTH-1][i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_cnt <= '0;
        end else if (cnt_clr) begin
            flag_cnt <= '0;
        end else if (out_valid && out_flag && (flag_cnt != {CNT_W{1'b1}})) begin
            flag_cnt <= flag_cnt + 1'b1;
        end
    end

`ifdef PARAM_FLAG_SAMPLER_EDGE_DET_EN
    logic prev_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_flag <= 1'b0;
        end else if (out_valid) begin
            prev_flag <= out_flag;
        end
    end

    assign flag_rise = out_valid &  out_flag & ~prev_flag;
    assign flag_fall = out_valid & ~out_flag &  prev_flag;
`else
    assign flag_rise = 1'b0;
    assign flag_fall = 1'b0;
`endif

endmodule
